// File: rtl/ntt_pointwise_engine.sv
// ntt_pointwise_engine: streams DEPTH words through a pipelined modular multiply.
// Modes: 0=PRODUCT (a*b), 1=SCALE (a*NINV), 2=REVSCALE (a[-i]*NINV), 3=reserved (err).
// Optional feature macro: NTT_PW_CHECKSUM_EN builds a running sum (mod MOD) of written words.
module ntt_pointwise_engine #(
   parameter int              DEPTH  = 1024,
   parameter int              SIZE   = 32,
   parameter longint unsigned MOD    = 998244353,
   parameter longint unsigned NINV   = 997269505,
   parameter int              RD_LAT = 1,
   localparam int             AW     = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [1:0]      mode,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic [AW-1:0]   a_addr,
   output logic            a_re,
   input  logic [SIZE-1:0] a_q,
   output logic [AW-1:0]   b_addr,
   output logic            b_re,
   input  logic [SIZE-1:0] b_q,
   output logic [AW-1:0]   r_addr,
   output logic            r_we,
   output logic [SIZE-1:0] r_d,
   output logic [SIZE-1:0] checksum
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   localparam logic [1:0]        M_PRODUCT  = 2'd0;
   localparam logic [1:0]        M_REVSCALE = 2'd2;
   localparam logic [1:0]        M_RSVD     = 2'd3;
   localparam logic [2*SIZE-1:0] MOD_W      = (2*SIZE)'(MOD);
   localparam logic [SIZE-1:0]   NINV_W     = SIZE'(NINV);

   state_t              state_q, state_d;
   logic [AW-1:0]       cnt_q, cnt_d;
   logic [1:0]          mode_q, mode_d;
   logic                err_q, err_d;
   logic [RD_LAT+1:0]   tok_q;
   logic [AW-1:0]       idx_q [RD_LAT+2];
   logic [2*SIZE-1:0]   prod_q;
   logic [SIZE-1:0]     red_q;

   logic                issue;
   logic                accept;
   logic [AW-1:0]       rev_addr;
   logic [SIZE-1:0]     mult_b;
   logic [2*SIZE-1:0]   prod_d;

   assign issue    = (state_q == S_RUN);
   assign accept   = (state_q == S_IDLE) && start;
   assign rev_addr = AW'(0) - cnt_q;

   // State, index counter, latched mode and error flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         mode_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic; the drain ends once only the write stage may still hold a token
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               mode_d  = mode;
               err_d   = (mode == M_RSVD);
               cnt_d   = '0;
               state_d = (mode == M_RSVD) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == AW'(DEPTH - 1)) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (tok_q[RD_LAT:0] == '0) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Read-port issue: addresses and enables are zero outside RUN
   always_comb begin
      a_re   = issue;
      a_addr = '0;
      b_re   = issue && (mode_q == M_PRODUCT);
      b_addr = '0;
      if (issue) a_addr = (mode_q == M_REVSCALE) ? rev_addr : cnt_q;
      if (b_re)  b_addr = cnt_q;
   end

   assign mult_b = (mode_q == M_PRODUCT) ? b_q : NINV_W;
   assign prod_d = (2*SIZE)'(a_q) * (2*SIZE)'(mult_b);

   // Valid tokens, multiply register and reduce register; idle stages carry zeros
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tok_q  <= '0;
         prod_q <= '0;
         red_q  <= '0;
      end else begin
         tok_q  <= {tok_q[RD_LAT:0], issue};
         prod_q <= tok_q[RD_LAT-1] ? prod_d : '0;
         red_q  <= tok_q[RD_LAT] ? SIZE'(prod_q % MOD_W) : '0;
      end
   end

   // Destination index travels alongside its token
   generate
      for (genvar gi = 0; gi < RD_LAT + 2; gi++) begin : g_idx
         if (gi == 0) begin : g_head
            // Capture the issued index (zero when nothing is issued)
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) idx_q[0] <= '0;
               else        idx_q[0] <= issue ? cnt_q : '0;
            end
         end else begin : g_tail
            // Shift the index one stage further
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) idx_q[gi] <= '0;
               else        idx_q[gi] <= idx_q[gi-1];
            end
         end
      end
   endgenerate

   assign r_we   = tok_q[RD_LAT+1];
   assign r_addr = idx_q[RD_LAT+1];
   assign r_d    = red_q;
   assign busy   = (state_q != S_IDLE);
   assign done   = (state_q == S_DONE);
   assign err    = err_q;

`ifdef NTT_PW_CHECKSUM_EN
   localparam logic [SIZE:0] MOD_S = (SIZE+1)'(MOD);
   logic [SIZE-1:0] sum_q;
   logic [SIZE:0]   sum_raw;

   assign sum_raw = {1'b0, sum_q} + {1'b0, red_q};

   // Modular accumulation of every written word; both operands are below MOD
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      sum_q <= '0;
      else if (accept) sum_q <= '0;
      else if (r_we)   sum_q <= (sum_raw >= MOD_S) ? SIZE'(sum_raw - MOD_S) : sum_raw[SIZE-1:0];
   end

   assign checksum = sum_q;
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_ntt_pointwise_engine.sv
// Scoreboard bench for ntt_pointwise_engine (DEPTH=8, RD_LAT=1).
// Stimulus pushes expected issues/writes into queues; a negedge monitor pops and compares.
module tb_ntt_pointwise_engine;
   localparam int              DEPTH  = 8;
   localparam int              SIZE   = 32;
   localparam int              RD_LAT = 1;
   localparam int              AW     = 3;
   localparam longint unsigned MOD    = 998244353;
   localparam longint unsigned NINV   = 873463809;
   localparam int              DONE_CYC = DEPTH + RD_LAT + 3;
`ifdef NTT_PW_CHECKSUM_EN
   localparam logic CK_EN = 1'b1;
`else
   localparam logic CK_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic [1:0]      mode = 2'd0;
   logic            busy, done, err, a_re, b_re, r_we;
   logic [AW-1:0]   a_addr, b_addr, r_addr;
   logic [SIZE-1:0] a_q, b_q, r_d, checksum;

   logic [SIZE-1:0] mem_a [DEPTH];
   logic [SIZE-1:0] mem_b [DEPTH];
   logic [SIZE-1:0] exp_r [DEPTH];

   typedef struct { int cyc; logic [AW-1:0] addr; logic [SIZE-1:0] data; } wr_t;
   typedef struct { logic [AW-1:0] a_addr; logic b_re; } iss_t;
   wr_t  wr_q[$];
   iss_t iss_q[$];

   int checks = 0;
   int errors = 0;
   int wr_seen = 0;
   int edge_cnt = 0;
   int start_edge = 0;

   ntt_pointwise_engine #(
      .DEPTH(DEPTH), .SIZE(SIZE), .MOD(MOD), .NINV(NINV), .RD_LAT(RD_LAT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
      .busy(busy), .done(done), .err(err),
      .a_addr(a_addr), .a_re(a_re), .a_q(a_q),
      .b_addr(b_addr), .b_re(b_re), .b_q(b_q),
      .r_addr(r_addr), .r_we(r_we), .r_d(r_d),
      .checksum(checksum)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // Source memories with one cycle read latency
   always @(posedge clk) begin
      a_q <= mem_a[a_addr];
      b_q <= mem_b[b_addr];
   end

   function automatic int cur_cycle();
      return edge_cnt - start_edge + 1;
   endfunction

   // Monitor: every enable must match the next expected transaction
   always @(negedge clk) begin
      wr_t  w;
      iss_t s;
      if (r_we) begin
         wr_seen++;
         checks++;
         if (wr_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: r_addr=%0d r_d=%0d, required no write", r_addr, r_d);
         end else begin
            w = wr_q.pop_front();
            $display("write cycle=%0d r_addr=%0d r_d=%0d", cur_cycle(), r_addr, r_d);
            if (r_addr !== w.addr || r_d !== w.data || cur_cycle() != w.cyc) begin
               errors++;
               $display("FAIL write: got addr=%0d data=%0d cycle=%0d, required addr=%0d data=%0d cycle=%0d",
                        r_addr, r_d, cur_cycle(), w.addr, w.data, w.cyc);
            end
         end
      end
      if (a_re || b_re) begin
         checks++;
         if (iss_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_read: a_re=%b b_re=%b a_addr=%0d, required no read", a_re, b_re, a_addr);
         end else begin
            s = iss_q.pop_front();
            if (a_re !== 1'b1 || a_addr !== s.a_addr || b_re !== s.b_re ||
                b_addr !== (s.b_re ? s.a_addr : AW'(0))) begin
               errors++;
               $display("FAIL issue: got a_re=%b a_addr=%0d b_re=%b b_addr=%0d, required a_re=1 a_addr=%0d b_re=%b",
                        a_re, a_addr, b_re, b_addr, s.a_addr, s.b_re);
            end
         end
      end
   end

   task automatic push_run(input logic [1:0] m);
      for (int i = 0; i < DEPTH; i++) begin
         iss_t s;
         wr_t  w;
         s.a_addr = (m == 2'd2) ? AW'((DEPTH - i) % DEPTH) : AW'(i);
         s.b_re   = (m == 2'd0);
         iss_q.push_back(s);
         w.cyc  = 4 + i;
         w.addr = AW'(i);
         w.data = exp_r[i];
         wr_q.push_back(w);
      end
   endtask

   // Drive a one-cycle start; returns at the negedge of cycle 1
   task automatic issue_start(input logic [1:0] m);
      @(negedge clk);
      start = 1'b1;
      mode = m;
      start_edge = edge_cnt + 1;
      @(negedge clk);
      start = 1'b0;
      mode = 2'd0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_cycle1: busy=%b, required 1", busy);
      end
   endtask

   task automatic wait_done(input int exp_cyc, input logic exp_err, input logic [SIZE-1:0] exp_ck);
      int n;
      n = 0;
      while (done !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, n);
      end else if (cur_cycle() != exp_cyc || err !== exp_err) begin
         errors++;
         $display("FAIL done: got cycle=%0d err=%b, required cycle=%0d err=%b", cur_cycle(), err, exp_cyc, exp_err);
      end
      checks++;
      if (checksum !== (exp_ck & {SIZE{CK_EN}})) begin
         errors++;
         $display("FAIL checksum: got %0d, required %0d", checksum, exp_ck & {SIZE{CK_EN}});
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL after_done: busy=%b done=%b, required 0 0", busy, done);
      end
      checks++;
      if (wr_q.size() != 0 || iss_q.size() != 0) begin
         errors++;
         $display("FAIL missing: %0d writes and %0d issues outstanding, required 0 0", wr_q.size(), iss_q.size());
      end
   endtask

   task automatic run_case(input logic [1:0] m, input logic [SIZE-1:0] exp_ck);
      $display("run mode=%0d", m);
      push_run(m);
      issue_start(m);
      wait_done(DONE_CYC, 1'b0, exp_ck);
   endtask

   task automatic load_scn1();
      for (int i = 0; i < DEPTH; i++) begin
         mem_a[i] = SIZE'(i + 1);
         mem_b[i] = 32'd2;
         exp_r[i] = SIZE'(2 * i + 2);
      end
   endtask

   task automatic check_all_zero(input string tag);
      checks++;
      if ({a_addr, a_re, b_addr, b_re, r_addr, r_we, r_d, busy, done, err, checksum} !== '0) begin
         errors++;
         $display("FAIL %s: a_re=%b b_re=%b r_we=%b a_addr=%0d r_addr=%0d r_d=%0d busy=%b done=%b err=%b checksum=%0d, required all 0",
                  tag, a_re, b_re, r_we, a_addr, r_addr, r_d, busy, done, err, checksum);
      end
   endtask

   initial begin
      int base;
      logic [SIZE-1:0] rev_tab [DEPTH];
      rev_tab = '{32'd0, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
      for (int i = 0; i < DEPTH; i++) begin
         mem_a[i] = '0;
         mem_b[i] = '0;
      end
      repeat (2) @(negedge clk);
      check_all_zero("reset_state");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 1: PRODUCT a=i+1, b=2
      load_scn1();
      run_case(2'd0, 32'd72);

      // 2: PRODUCT (MOD-1)^2 -> 1
      for (int i = 0; i < DEPTH; i++) begin
         mem_a[i] = 32'd998244352;
         mem_b[i] = 32'd998244352;
         exp_r[i] = 32'd1;
      end
      run_case(2'd0, 32'd8);

      // 3: REVSCALE a=8i -> r[0]=0, r[i]=8-i
      for (int i = 0; i < DEPTH; i++) begin
         mem_a[i] = SIZE'(8 * i);
         exp_r[i] = rev_tab[i];
      end
      run_case(2'd2, 32'd28);

      // 4: reserved mode, then PRODUCT clears err
      $display("run mode=3");
      issue_start(2'd3);
      wait_done(1, 1'b1, 32'd0);
      load_scn1();
      run_case(2'd0, 32'd72);

      // 5: ignored restart, then reset after the 4th write
      $display("run mode=0 with restart and reset");
      base = wr_seen;
      push_run(2'd0);
      issue_start(2'd0);
      @(negedge clk);
      @(negedge clk);
      start = 1'b1;
      mode = 2'd2;
      @(negedge clk);
      start = 1'b0;
      mode = 2'd0;
      for (int k = 0; k < 20 && cur_cycle() < 7; k++) @(negedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      wr_q.delete();
      iss_q.delete();
      checks++;
      if (wr_seen - base != 4) begin
         errors++;
         $display("FAIL writes_before_reset: got %0d, required 4", wr_seen - base);
      end
      @(negedge clk);
      check_all_zero("mid_run_reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check_all_zero("idle_after_reset");
      run_case(2'd0, 32'd72);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required finish");
      $fatal(1, "timeout");
   end

endmodule
